data_router: RTL and testbench

- Sits directly downstream of the input-pulse stage. Consumes single-cycle byte pulses tagged key/data.
- Key bytes are assembled into a KEY_BYTES-wide key register for the cipher core.
- Data bytes are queued in a small FIFO and drained to the cipher core over a valid/ready interface.
- Reports fullness to the interface FSM and keeps sticky error flags for dropped bytes.

---
 rtl/data_router.sv | 202 ++++++++++++++++++++
 tb/tb_data_router.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_router.sv
// data_router: assembles tagged key bytes into a KEY_BYTES-wide key and
// queues data bytes in a FIFO_DEPTH-entry FIFO drained over valid/ready.
//
// Optional feature macro: DATA_ROUTER_KEY_FLUSH_EN
//   defined   - the first byte of a new key flushes the data FIFO
//   undefined - the FIFO is untouched by key traffic
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   input_byte_pulsed   - byte qualified by input_byte_pulse
//   is_key_pulsed       - 1 = key byte, 0 = data byte
//   input_byte_pulse    - single-cycle strobe
//   clear_errors        - clears sticky error flags
//   key_out             - last completed key, first byte in MS byte
//   key_valid           - key_out complete and current
//   key_update_pulse    - one cycle high when a key completes
//   data_out/data_valid - FIFO head byte / FIFO non-empty
//   data_ready          - consumer accepts head on data_valid && data_ready
//   router_full         - FIFO holds FIFO_DEPTH entries
//   err_no_key          - sticky: data byte dropped, no valid key
//   err_overflow        - sticky: data byte dropped, FIFO full
module data_router #(
  parameter int unsigned KEY_BYTES  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             input_byte_pulsed,
  input  logic                   is_key_pulsed,
  input  logic                   input_byte_pulse,
  input  logic                   clear_errors,
  output logic [8*KEY_BYTES-1:0] key_out,
  output logic                   key_valid,
  output logic                   key_update_pulse,
  output logic [7:0]             data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   router_full,
  output logic                   err_no_key,
  output logic                   err_overflow
);

  localparam int unsigned KW  = 8 * KEY_BYTES;
  localparam int unsigned AW  = 8 * (KEY_BYTES - 1);
  localparam int unsigned KCW = $clog2(KEY_BYTES);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [KCW-1:0] KCNT_LAST = KCW'(KEY_BYTES - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    KEY_EMPTY,
    KEY_PARTIAL,
    KEY_READY
  } key_state_e;

  // ---------------------------------------------------------------------
  // Key assembly FSM
  // ---------------------------------------------------------------------
  key_state_e     key_state_q;
  logic [AW-1:0]  asm_q;
  logic [KCW-1:0] kcnt_q;
  logic [KW-1:0]  key_out_q;
  logic           key_valid_q;
  logic           key_upd_q;

  logic           key_pulse;
  logic           data_pulse;
  logic [KW-1:0]  key_shift;

  assign key_pulse  = input_byte_pulse && is_key_pulsed;
  assign data_pulse = input_byte_pulse && !is_key_pulsed;
  // Assembly only ever holds KEY_BYTES-1 bytes; the final byte is appended
  // straight into key_out when the key completes.
  assign key_shift  = {asm_q, input_byte_pulsed};

  always_ff @(posedge clk) begin
    if (rst) begin
      key_state_q <= KEY_EMPTY;
      asm_q       <= '0;
      kcnt_q      <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      key_upd_q   <= 1'b0;
    end else begin
      key_upd_q <= 1'b0;
      if (key_pulse) begin
        case (key_state_q)
          KEY_PARTIAL: begin
            if (kcnt_q == KCNT_LAST) begin
              key_out_q   <= key_shift;
              key_valid_q <= 1'b1;
              key_upd_q   <= 1'b1;
              kcnt_q      <= '0;
              key_state_q <= KEY_READY;
            end else begin
              asm_q  <= key_shift[AW-1:0];
              kcnt_q <= kcnt_q + KCW'(1);
            end
          end
          default: begin
            asm_q       <= AW'(input_byte_pulsed);
            kcnt_q      <= KCW'(1);
            key_valid_q <= 1'b0;
            key_state_q <= KEY_PARTIAL;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Data FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    dout_q, dout_d;
  logic          dv_q, full_q;
  logic          eno_q, eno_d;
  logic          eov_q, eov_d;

  logic          flush;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          ovf_evt;
  logic          nokey_evt;

  always_comb begin
    flush = 1'b0;
`ifdef DATA_ROUTER_KEY_FLUSH_EN
    flush = key_pulse && (key_state_q != KEY_PARTIAL);
`endif
    pop       = dv_q && data_ready && !flush;
    push_req  = data_pulse && key_valid_q;
    // Full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok   = push_req && ((cnt_q != FULL_CNT) || pop);
    ovf_evt   = push_req && !push_ok;
    nokey_evt = data_pulse && !key_valid_q;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push_ok) cnt_d = cnt_q - CW'(1);
    end

    // Registered head: when the next head is the byte being written this
    // cycle it is not in storage yet, so bypass it from the input.
    if (push_ok && (rd_ptr_d == wr_ptr_q)) dout_d = input_byte_pulsed;
    else                                   dout_d = mem_q[rd_ptr_d];

    // Same-cycle error event wins over clear_errors.
    eno_d = (eno_q && !clear_errors) || nokey_evt;
    eov_d = (eov_q && !clear_errors) || ovf_evt;
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= input_byte_pulsed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      full_q   <= 1'b0;
      eno_q    <= 1'b0;
      eov_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dv_q     <= (cnt_d != '0);
      full_q   <= (cnt_d == FULL_CNT);
      eno_q    <= eno_d;
      eov_q    <= eov_d;
    end
  end

  assign key_out          = key_out_q;
  assign key_valid        = key_valid_q;
  assign key_update_pulse = key_upd_q;
  assign data_out         = dout_q;
  assign data_valid       = dv_q;
  assign router_full      = full_q;
  assign err_no_key       = eno_q;
  assign err_overflow     = eov_q;

endmodule

// File: tb/tb_data_router.sv
// tb_data_router: directed self-checking bench for data_router.
// Expected FIFO contents live in a scoreboard queue pushed when a data byte
// is driven and popped when the DUT presents a byte that is consumed.
module tb_data_router;

  localparam int unsigned KB    = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    input_byte_pulsed = '0;
  logic          is_key_pulsed = 1'b0;
  logic          input_byte_pulse = 1'b0;
  logic          clear_errors = 1'b0;
  logic [8*KB-1:0] key_out;
  logic          key_valid;
  logic          key_update_pulse;
  logic [7:0]    data_out;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic          router_full;
  logic          err_no_key;
  logic          err_overflow;

  always #5 clk = ~clk;

  data_router #(
    .KEY_BYTES (KB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .input_byte_pulsed(input_byte_pulsed),
    .is_key_pulsed    (is_key_pulsed),
    .input_byte_pulse (input_byte_pulse),
    .clear_errors     (clear_errors),
    .key_out          (key_out),
    .key_valid        (key_valid),
    .key_update_pulse (key_update_pulse),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .router_full      (router_full),
    .err_no_key       (err_no_key),
    .err_overflow     (err_overflow)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [7:0]  exp_q[$];
  bit          m_kv;
  bit          m_nokey;
  bit          m_ovf;
  int unsigned m_kcnt;
  logic [31:0] m_asm;
  logic [31:0] m_key;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; checks and consumes the head byte if the model expects
  // a pop this cycle, and applies a data push to the model.
  task automatic tick_sb(input bit push_req, input logic [7:0] b, input bit flush);
    bit          pop_now;
    int unsigned sz;
    sz = exp_q.size();
    chk("data_valid", 32'(data_valid), 32'(sz != 0));
    pop_now = (sz != 0) && data_ready && !flush;
    if (pop_now) begin
      chk("data_out", 32'(data_out), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (clear_errors) begin
      m_nokey = 1'b0;
      m_ovf   = 1'b0;
    end
    if (push_req) begin
      if (!m_kv)                          m_nokey = 1'b1;
      else if (sz < DEPTH || pop_now)     exp_q.push_back(b);
      else                                m_ovf = 1'b1;
    end
    if (flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick_sb(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_key(input logic [7:0] b);
    bit fl;
    bit upd;
    fl  = 1'b0;
    upd = 1'b0;
    input_byte_pulsed = b;
    is_key_pulsed     = 1'b1;
    input_byte_pulse  = 1'b1;
    if (m_kcnt == 0) begin
`ifdef DATA_ROUTER_KEY_FLUSH_EN
      fl = 1'b1;
`endif
      m_asm  = {24'd0, b};
      m_kcnt = 1;
      m_kv   = 1'b0;
    end else if (m_kcnt == KB - 1) begin
      m_key  = {m_asm[23:0], b};
      m_kv   = 1'b1;
      m_kcnt = 0;
      upd    = 1'b1;
    end else begin
      m_asm  = {m_asm[23:0], b};
      m_kcnt = m_kcnt + 1;
    end
    tick_sb(1'b0, 8'h00, fl);
    input_byte_pulse = 1'b0;
    is_key_pulsed    = 1'b0;
    chk("key_valid", 32'(key_valid), 32'(m_kv));
    chk("key_update_pulse", 32'(key_update_pulse), 32'(upd));
    chk("key_out", key_out, m_key);
  endtask

  task automatic send_data(input logic [7:0] b);
    input_byte_pulsed = b;
    is_key_pulsed     = 1'b0;
    input_byte_pulse  = 1'b1;
    tick_sb(1'b1, b, 1'b0);
    input_byte_pulse = 1'b0;
    chk("err_no_key", 32'(err_no_key), 32'(m_nokey));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("router_full", 32'(router_full), 32'(exp_q.size() == DEPTH));
  endtask

  task automatic clear_errs();
    clear_errors = 1'b1;
    tick_sb(1'b0, 8'h00, 1'b0);
    clear_errors = 1'b0;
    chk("err_no_key_clr", 32'(err_no_key), 32'(m_nokey));
    chk("err_overflow_clr", 32'(err_overflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    input_byte_pulse = 1'b0;
    is_key_pulsed    = 1'b0;
    exp_q.delete();
    m_kv    = 1'b0;
    m_nokey = 1'b0;
    m_ovf   = 1'b0;
    m_kcnt  = 0;
    m_asm   = '0;
    m_key   = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".key_out"}, key_out, 32'h0);
    chk({tag, ".key_valid"}, 32'(key_valid), 32'h0);
    chk({tag, ".key_update_pulse"}, 32'(key_update_pulse), 32'h0);
    chk({tag, ".data_out"}, 32'(data_out), 32'h0);
    chk({tag, ".data_valid"}, 32'(data_valid), 32'h0);
    chk({tag, ".router_full"}, 32'(router_full), 32'h0);
    chk({tag, ".err_no_key"}, 32'(err_no_key), 32'h0);
    chk({tag, ".err_overflow"}, 32'(err_overflow), 32'h0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_zero("reset");

    // Data with no key is dropped and flagged, then cleared
    send_data(8'hA5);
    chk("no_key_set", 32'(err_no_key), 32'h1);
    idle(1);
    chk("no_key_dv", 32'(data_valid), 32'h0);
    clear_errs();
    chk("no_key_cleared", 32'(err_no_key), 32'h0);

    // Key assembly with idle gaps
    send_key(8'h11); idle(1);
    send_key(8'h22); idle(1);
    send_key(8'h33); idle(1);
    send_key(8'h44);
    chk("key_full", key_out, 32'h11223344);
    chk("key_upd_hi", 32'(key_update_pulse), 32'h1);
    idle(1);
    chk("key_upd_lo", 32'(key_update_pulse), 32'h0);

    // Fill to full, fifth byte overflows, then drain in order
    data_ready = 1'b0;
    for (int unsigned i = 1; i <= 5; i++) begin
      send_data(8'(i));
      if (i == 4) chk("full_after_4", 32'(router_full), 32'h1);
    end
    chk("ovf_set", 32'(err_overflow), 32'h1);
    data_ready = 1'b1;
    idle(5);
    chk("drained_dv", 32'(data_valid), 32'h0);
    clear_errs();

    // Overflow event in the same cycle as clear_errors: event wins
    data_ready = 1'b0;
    send_data(8'h10); send_data(8'h20); send_data(8'h30); send_data(8'h40);
    clear_errors = 1'b1;
    send_data(8'h50);
    clear_errors = 1'b0;
    chk("ovf_beats_clear", 32'(err_overflow), 32'h1);
    clear_errs();

    // Push into a full FIFO with a simultaneous pop is accepted
    data_ready = 1'b1;
    send_data(8'h77);
    chk("full_push_pop_full", 32'(router_full), 32'h1);
    chk("full_push_pop_ovf", 32'(err_overflow), 32'h0);
    idle(5);
    chk("drain77_dv", 32'(data_valid), 32'h0);

    // New key while data is queued
    data_ready = 1'b0;
    send_data(8'hB1);
    send_data(8'hB2);
    send_key(8'h99);
    chk("rekey_kv", 32'(key_valid), 32'h0);
    chk("rekey_key_hold", key_out, 32'h11223344);
    idle(1);
    send_data(8'hC3);
    chk("rekey_no_key", 32'(err_no_key), 32'h1);
    data_ready = 1'b1;
    idle(4);
    chk("rekey_drained", 32'(data_valid), 32'h0);
    data_ready = 1'b0;
    clear_errs();

    // Reset mid-key (count=2) with a pulse present
    send_key(8'h55);
    input_byte_pulsed = 8'h66;
    is_key_pulsed     = 1'b1;
    input_byte_pulse  = 1'b1;
    do_reset();
    check_zero("midkey_reset");

    // Fresh key after reset completes on exactly the fourth byte
    send_key(8'hA1);
    send_key(8'hB2);
    send_key(8'hC3);
    chk("post_reset_kv_3", 32'(key_valid), 32'h0);
    send_key(8'hD4);
    chk("post_reset_key", key_out, 32'hA1B2C3D4);
    chk("post_reset_upd", 32'(key_update_pulse), 32'h1);
    send_data(8'hE7);
    data_ready = 1'b1;
    idle(2);
    chk("post_reset_dv", 32'(data_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
